// File: rtl/retro1_ctl_pkg.sv
// Shared types and default constants for the retro1 serial controller scanner.
package retro1_ctl_pkg;

    localparam int PORTS_DEF  = 2;
    localparam int BITS_DEF   = 16;
    localparam int CLKDIV_DEF = 4;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LATCH = 3'd1,
        ST_LOW   = 3'd2,
        ST_HIGH  = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

endpackage

// File: rtl/retro1_sync2.sv
// Two-flop synchroniser; resets to all ones because pad data idles high (released).
module retro1_sync2 #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk) begin
        if (reset) begin
            meta <= '1;
            q    <= '1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/retro1_controller_scanner.sv
// Scans PORTS serial game pads (NES/SNES style) over a shared latch/clock pair and
// publishes the last complete set of button states with a one-cycle valid pulse.
module retro1_controller_scanner
    import retro1_ctl_pkg::*;
#(
    parameter int PORTS  = PORTS_DEF,
    parameter int BITS   = BITS_DEF,
    parameter int CLKDIV = CLKDIV_DEF
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       pause,
    input  logic                       poll,
    input  logic [PORTS-1:0]           ctl_data,
    output logic                       ctl_latch,
    output logic                       ctl_clk,
    output logic [PORTS-1:0][BITS-1:0] buttons,
    output logic                       valid,
    output logic                       busy,
    output logic [2:0]                 dbg_state
);

    localparam int DW = $clog2(CLKDIV);
    localparam int BW = $clog2(BITS);
    localparam logic [DW-1:0] DIV_LAST = DW'(CLKDIV - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(BITS - 1);

    state_t                     state;
    logic [DW-1:0]              div_cnt;
    logic [BW-1:0]              bit_cnt;
    logic                       half;
    logic                       pending;
    logic [PORTS-1:0]           data_s;
    logic [PORTS-1:0][BITS-1:0] shreg;
    logic [PORTS-1:0][BITS-1:0] shreg_next;
    logic                       div_end;

    retro1_sync2 #(.WIDTH(PORTS)) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (ctl_data),
        .q     (data_s)
    );

    // First bit out lands in bit 0 after BITS right-shifts.
    always_comb begin
        shreg_next = shreg;
        for (int p = 0; p < PORTS; p++) begin
            shreg_next[p] = {data_s[p], shreg[p][BITS-1:1]};
        end
    end

    assign div_end   = (div_cnt == DIV_LAST);
    assign busy      = (state != ST_IDLE);
    assign valid     = (state == ST_DONE) && !pause;
    assign dbg_state = state;

    // Valid/pending contract: poll is a one-cycle request; a request while busy
    // (or while paused in idle) is remembered once, extra requests are dropped.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            div_cnt   <= '0;
            bit_cnt   <= '0;
            half      <= 1'b0;
            pending   <= 1'b0;
            ctl_latch <= 1'b0;
            ctl_clk   <= 1'b1;
            shreg     <= '0;
            buttons   <= '0;
        end else begin
            if (poll && (state != ST_IDLE || pause)) begin
                pending <= 1'b1;
            end
            if (!pause) begin
                case (state)
                    ST_IDLE: begin
                        if (poll || pending) begin
                            state     <= ST_LATCH;
                            ctl_latch <= 1'b1;
                            pending   <= 1'b0;
                            div_cnt   <= '0;
                            half      <= 1'b0;
                        end
                    end
                    ST_LATCH: begin
                        if (div_end) begin
                            div_cnt <= '0;
                            if (half) begin
                                shreg     <= shreg_next;
                                bit_cnt   <= BW'(1);
                                half      <= 1'b0;
                                ctl_latch <= 1'b0;
                                ctl_clk   <= 1'b0;
                                state     <= ST_LOW;
                            end else begin
                                half <= 1'b1;
                            end
                        end else begin
                            div_cnt <= div_cnt + 1'b1;
                        end
                    end
                    ST_LOW: begin
                        if (div_end) begin
                            div_cnt <= '0;
                            ctl_clk <= 1'b1;
                            state   <= ST_HIGH;
                        end else begin
                            div_cnt <= div_cnt + 1'b1;
                        end
                    end
                    ST_HIGH: begin
                        if (div_end) begin
                            div_cnt <= '0;
                            shreg   <= shreg_next;
                            if (bit_cnt == BIT_LAST) begin
                                buttons <= ~shreg_next;
                                state   <= ST_DONE;
                            end else begin
                                bit_cnt <= bit_cnt + 1'b1;
                                ctl_clk <= 1'b0;
                                state   <= ST_LOW;
                            end
                        end else begin
                            div_cnt <= div_cnt + 1'b1;
                        end
                    end
                    ST_DONE: begin
                        bit_cnt <= '0;
                        div_cnt <= '0;
                        half    <= 1'b0;
                        if (pending || poll) begin
                            pending   <= 1'b0;
                            ctl_latch <= 1'b1;
                            state     <= ST_LATCH;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end
                    default: begin
                        state     <= ST_IDLE;
                        ctl_latch <= 1'b0;
                        ctl_clk   <= 1'b1;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_retro1_controller_scanner.sv
// Bench for retro1_controller_scanner: a 2x16/div4 instance and a 1x8/div2 instance
// share poll/pause/reset; pad models answer the latch/clock, a timing model predicts Valid.
module tb_retro1_controller_scanner;

    localparam int LA = 2*4*16 + 1;
    localparam int LB = 2*2*8 + 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset, pause, poll;

    logic [1:0]       data_a;
    logic [1:0][15:0] btn_a;
    logic             latch_a, cclk_a, valid_a, busy_a;
    logic [2:0]       st_a;

    logic [0:0]       data_b;
    logic [0:0][7:0]  btn_b;
    logic             latch_b, cclk_b, valid_b, busy_b;
    logic [2:0]       st_b;

    retro1_controller_scanner #(.PORTS(2), .BITS(16), .CLKDIV(4)) u_a (
        .clk(clk), .reset(reset), .pause(pause), .poll(poll), .ctl_data(data_a),
        .ctl_latch(latch_a), .ctl_clk(cclk_a), .buttons(btn_a), .valid(valid_a),
        .busy(busy_a), .dbg_state(st_a)
    );

    retro1_controller_scanner #(.PORTS(1), .BITS(8), .CLKDIV(2)) u_b (
        .clk(clk), .reset(reset), .pause(pause), .poll(poll), .ctl_data(data_b),
        .ctl_latch(latch_b), .ctl_clk(cclk_b), .buttons(btn_b), .valid(valid_b),
        .busy(busy_b), .dbg_state(st_b)
    );

    // Pad model: latch reloads, each falling shift clock presents the next bit (active-low).
    logic [15:0] pat0, pat1;
    logic [7:0]  patb;
    int          idx_a = 0, idx_b = 0;
    logic        prev_a = 1'b1, prev_b = 1'b1;

    always @(negedge clk) begin
        if (latch_a) idx_a <= 0;
        else if (prev_a && !cclk_a) idx_a <= idx_a + 1;
        prev_a <= cclk_a;
        if (latch_b) idx_b <= 0;
        else if (prev_b && !cclk_b) idx_b <= idx_b + 1;
        prev_b <= cclk_b;
    end

    assign data_a[0] = (idx_a < 16) ? ~pat0[idx_a[3:0]] : 1'b1;
    assign data_a[1] = (idx_a < 16) ? ~pat1[idx_a[3:0]] : 1'b1;
    assign data_b[0] = (idx_b < 8)  ? ~patb[idx_b[2:0]] : 1'b1;

    // Scoreboard
    int          n_cmp = 0, n_bad = 0;
    logic [31:0] exp_a_q[$], exp_b_q[$];
    logic [15:0] ebtn0, ebtn1;
    logic [7:0]  ebtnb;
    int          polls[$];
    int          ps, pl, rt;

    function automatic void check(string name, logic [31:0] got, logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endfunction

    // Timing model from the request rules: scan length L, one-deep pending,
    // pause stretches a scan, reset discards scans not yet complete.
    function automatic void build_exp(input int L, input bit is_a);
        int v[$];
        int p, e, st;
        bit rst_done;
        rst_done = 1'b0;
        foreach (polls[i]) begin
            p = polls[i];
            if (rt >= 0 && !rst_done && p > rt) begin
                while (v.size() > 0 && v[$] > rt) void'(v.pop_back());
                rst_done = 1'b1;
            end
            if (p == rt) continue;
            if (pl > 0 && p >= ps && p < ps + pl) p = ps + pl;
            if (v.size() > 0 && p <= v[$]) begin
                if (v.size() > 1 && p <= v[$-1]) continue;
                st = v[$];
            end else begin
                st = p;
            end
            e = st + L;
            if (pl > 0 && ps > st && ps <= e) e += pl;
            v.push_back(e);
        end
        if (rt >= 0 && !rst_done) begin
            while (v.size() > 0 && v[$] > rt) void'(v.pop_back());
        end
        foreach (v[i]) begin
            if (is_a) exp_a_q.push_back(32'(v[i]));
            else      exp_b_q.push_back(32'(v[i]));
        end
    endfunction

    int  seg[2], lows[2], bad[2], lat[2], idle_bad[2];
    bit  prv[2], vh[2];

    function automatic void track(int d, bit l, bit c, bit b, int cd);
        if (!b && !(c && !l)) idle_bad[d]++;
        if (l) begin
            lat[d]++;
            vh[d] = 1'b0;
        end
        if (c != prv[d]) begin
            if (!c) begin
                lows[d]++;
                if (vh[d] && seg[d] != cd) bad[d]++;
            end else begin
                if (seg[d] != cd) bad[d]++;
                vh[d] = 1'b1;
            end
            seg[d] = 1;
        end else begin
            seg[d]++;
        end
        prv[d] = c;
    endfunction

    task automatic run(input int ncyc, input bit stats);
        int          na, nb;
        logic [31:0] e;
        logic [1:0]  snap_a, snap_b;
        exp_a_q.delete();
        exp_b_q.delete();
        build_exp(LA, 1'b1);
        build_exp(LB, 1'b0);
        na = exp_a_q.size();
        nb = exp_b_q.size();
        snap_a = '0;
        snap_b = '0;
        for (int d = 0; d < 2; d++) begin
            seg[d] = 0; lows[d] = 0; bad[d] = 0; lat[d] = 0; idle_bad[d] = 0;
            prv[d] = 1'b1; vh[d] = 1'b0;
        end
        for (int t = 0; t < ncyc; t++) begin
            @(negedge clk);
            poll = 1'b0;
            foreach (polls[i]) if (polls[i] == t) poll = 1'b1;
            pause = (pl > 0 && t >= ps && t < ps + pl);
            reset = (t == rt);
            #1;
            if (valid_a) begin
                if (exp_a_q.size() == 0) check("a_extra_valid", 32'(t), 32'hffffffff);
                else begin
                    e = exp_a_q.pop_front();
                    check("a_valid_cycle", 32'(t), e);
                    check("a_buttons0", 32'(btn_a[0]), 32'(ebtn0));
                    check("a_buttons1", 32'(btn_a[1]), 32'(ebtn1));
                end
            end
            if (valid_b) begin
                if (exp_b_q.size() == 0) check("b_extra_valid", 32'(t), 32'hffffffff);
                else begin
                    e = exp_b_q.pop_front();
                    check("b_valid_cycle", 32'(t), e);
                    check("b_buttons0", 32'(btn_b[0]), 32'(ebtnb));
                end
            end
            if (pause) check("valid_in_pause", {30'd0, valid_a, valid_b}, 32'd0);
            if (pl > 0 && t == ps) begin
                snap_a = {latch_a, cclk_a};
                snap_b = {latch_b, cclk_b};
            end
            if (pl > 0 && t > ps && t <= ps + pl) begin
                check("a_pause_freeze", 32'({latch_a, cclk_a}), 32'(snap_a));
                check("b_pause_freeze", 32'({latch_b, cclk_b}), 32'(snap_b));
            end
            if (rt >= 0 && t == rt + 1) begin
                check("a_rst_busy_clk_latch", {29'd0, busy_a, cclk_a, latch_a}, 32'b010);
                check("b_rst_busy_clk_latch", {29'd0, busy_b, cclk_b, latch_b}, 32'b010);
                check("a_rst_buttons", 32'(btn_a), 32'd0);
                check("b_rst_buttons", 32'(btn_b), 32'd0);
            end
            track(0, latch_a, cclk_a, busy_a, 4);
            track(1, latch_b, cclk_b, busy_b, 2);
        end
        poll  = 1'b0;
        pause = 1'b0;
        reset = 1'b0;
        check("a_missing_valids", 32'(exp_a_q.size()), 32'd0);
        check("b_missing_valids", 32'(exp_b_q.size()), 32'd0);
        if (stats) begin
            check("a_latch_cycles", 32'(lat[0]), 32'(8 * na));
            check("a_clk_low_pulses", 32'(lows[0]), 32'(15 * na));
            check("a_clk_phase_len_errs", 32'(bad[0]), 32'd0);
            check("a_idle_lines", 32'(idle_bad[0]), 32'd0);
            check("b_latch_cycles", 32'(lat[1]), 32'(4 * nb));
            check("b_clk_low_pulses", 32'(lows[1]), 32'(7 * nb));
            check("b_clk_phase_len_errs", 32'(bad[1]), 32'd0);
            check("b_idle_lines", 32'(idle_bad[1]), 32'd0);
        end
    endtask

    typedef struct {
        logic [15:0] pat0, pat1;
        logic [7:0]  patb;
        logic [15:0] exp0, exp1;
        logic [7:0]  expb;
    } vec_t;

    vec_t vecs[5];

    initial begin
        int p1, p2, p3;
        vecs[0] = '{16'hA5C3, 16'h0001, 8'h81, 16'hA5C3, 16'h0001, 8'h81};
        vecs[1] = '{16'h0000, 16'hFFFF, 8'h00, 16'h0000, 16'hFFFF, 8'h00};
        vecs[2] = '{16'hFFFF, 16'h0000, 8'hFF, 16'hFFFF, 16'h0000, 8'hFF};
        vecs[3] = '{16'h8001, 16'h7FFE, 8'h7E, 16'h8001, 16'h7FFE, 8'h7E};
        vecs[4] = '{16'h1234, 16'hFEDC, 8'h3C, 16'h1234, 16'hFEDC, 8'h3C};

        reset = 1'b1; pause = 1'b0; poll = 1'b0;
        pat0 = '0; pat1 = '0; patb = '0;
        repeat (3) @(negedge clk);
        #1;
        check("a_reset_state", {29'd0, busy_a, cclk_a, latch_a}, 32'b010);
        check("a_reset_valid", {31'd0, valid_a}, 32'd0);
        check("a_reset_buttons", 32'(btn_a), 32'd0);
        check("b_reset_state", {29'd0, busy_b, cclk_b, latch_b}, 32'b010);
        check("b_reset_buttons", 32'(btn_b), 32'd0);
        reset = 1'b0;

        ps = 0; pl = 0; rt = -1;
        foreach (vecs[i]) begin
            pat0 = vecs[i].pat0; pat1 = vecs[i].pat1; patb = vecs[i].patb;
            ebtn0 = vecs[i].exp0; ebtn1 = vecs[i].exp1; ebtnb = vecs[i].expb;
            polls = '{0};
            run(170, 1'b1);
        end

        pat0 = 16'hA5C3; pat1 = 16'h0001; patb = 8'h81;
        ebtn0 = pat0; ebtn1 = pat1; ebtnb = patb;

        polls = '{0, 50, 60};
        run(300, 1'b1);

        polls = '{0}; ps = 40; pl = 20;
        run(200, 1'b0);

        polls = '{0, 80}; ps = 0; pl = 0; rt = 70;
        run(300, 1'b0);

        polls = '{8}; ps = 5; pl = 10; rt = -1;
        run(200, 1'b0);

        ps = 0; pl = 0; rt = -1;
        for (int r = 0; r < 6; r++) begin
            pat0 = 16'($urandom); pat1 = 16'($urandom); patb = 8'($urandom);
            ebtn0 = pat0; ebtn1 = pat1; ebtnb = patb;
            p1 = $urandom_range(0, 100);
            p2 = p1 + $urandom_range(1, 150);
            p3 = p2 + $urandom_range(1, 150);
            polls = '{p1, p2, p3};
            run(700, 1'b1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/retro1_controller_scanner.md
RETRO1_CONTROLLER_SCANNER -- requirements
Module: retro1_controller_scanner

Interface
REQ-001 SHALL have parameter PORTS, default 2; number of serial controller ports, legal range 1..4.
REQ-002 SHALL have parameter BITS, default 16; bits shifted per port per scan, legal range 8..32 (8 = NES pad, 16 = SNES pad).
REQ-003 SHALL have parameter CLKDIV, default 4; Clk cycles per serial half-period, legal range 2..4096.
REQ-004 SHALL use one clock; reset is synchronous and active-high.
REQ-005 Clk  in  1  system clock; all logic on rising edge.
REQ-006 Reset  in  1  synchronous, active-high.
REQ-007 Pause  in  1  level-sensitive; freezes the scan while high.
REQ-008 Poll  in  1  one-cycle request to start a scan.
REQ-009 CtlData  in  PORTS  serial data from each pad, active-low.
REQ-010 CtlLatch  out  1  shared latch/strobe to all pads, active-high.
REQ-011 CtlClk  out  1  shared shift clock; idles high.
REQ-012 Buttons  out  PORTS x BITS  last completed scan, 1 = pressed; bit 0 = first bit shifted out.
REQ-013 Valid  out  1  one-cycle pulse when Buttons updates.
REQ-014 Busy  out  1  high while a scan is in progress.

Function
REQ-015 SHALL pass each CtlData bit through a 2-flop synchroniser; the sampled value SHALL be CtlData as it was 2 cycles earlier.
REQ-016 SHALL implement FSM states IDLE, LATCH, LOW, HIGH, DONE.
REQ-017 IDLE: CtlLatch=0, CtlClk=1, Busy=0. Poll=1 -> LATCH on the next cycle.
REQ-018 LATCH: CtlLatch=1 for 2*CLKDIV cycles. Bit 0 SHALL be sampled on the last LATCH cycle. Exit -> LOW, or -> DONE if BITS=1 (not legal; no requirement).
REQ-019 LOW: CtlClk=0 for CLKDIV cycles, then -> HIGH.
REQ-020 HIGH: CtlClk=1 for CLKDIV cycles. Bit k SHALL be sampled on the last cycle of the k-th HIGH phase. The state SHALL go -> LOW until bit BITS-1 is taken, then -> DONE.
REQ-021 DONE: lasts one cycle. Buttons SHALL load the inverted shift registers. Valid=1. The state SHALL go -> LATCH if a Poll is pending, else -> IDLE.
REQ-022 Busy SHALL be high in LATCH, LOW, HIGH and DONE.
REQ-023 Latency: Valid SHALL assert exactly 2*CLKDIV*BITS+1 cycles after the cycle in which Poll was sampled in IDLE (Pause low throughout).
REQ-024 A Poll while Busy SHALL set a one-deep pending flag. Further Polls while pending SHALL be dropped. The pending flag SHALL clear when the next scan enters LATCH.
REQ-025 Pause=1 SHALL freeze the divider counter, bit counter, FSM state, CtlLatch and CtlClk, and SHALL inhibit sampling. Valid SHALL NOT assert while Pause=1; a DONE reached under Pause SHALL hold until Pause falls.
REQ-026 Pause=1 in IDLE SHALL still register Poll as pending. The scan SHALL start on the first cycle with Pause=0.
REQ-027 The divider counter width SHALL be $clog2(CLKDIV) bits and SHALL wrap to 0 at CLKDIV-1. The bit counter width SHALL be $clog2(BITS) bits.
REQ-028 Buttons SHALL hold its value between Valid pulses. A partial scan SHALL never be visible on Buttons.

Reset
REQ-029 Reset SHALL be synchronous. On Reset: state=IDLE, CtlLatch=0, CtlClk=1, Valid=0, Busy=0, Buttons=0, pending=0, counters=0, synchronisers=1 (released).
REQ-030 Reset mid-scan SHALL abort on the next edge with no Valid pulse. Buttons SHALL be cleared to 0.
REQ-031 Reset SHALL take priority over Pause and Poll.

Structure
REQ-032 Package retro1_ctl_pkg SHALL hold the FSM state enum and the default constants PORTS_DEF=2, BITS_DEF=16, CLKDIV_DEF=4.
REQ-033 SHALL instantiate sub-module retro1_sync2 (2-flop synchroniser, parametrised width) once, with width PORTS.
REQ-034 One counter pair shared by all ports. Per-port BITS-wide shift registers.

Verification
REQ-035 PORTS=2, BITS=16, CLKDIV=4. Pad model 0 returns pressed pattern 16'hA5C3; pad 1 returns 16'h0001. Poll at cycle 0 -> Valid at cycle 129, Buttons[0]=16'hA5C3, Buttons[1]=16'h0001.
REQ-036 Same config. Measure CtlLatch and CtlClk. -> CtlLatch high 8 cycles. Exactly 15 CtlClk low pulses of 4 cycles each, separated by 4-cycle highs. CtlClk high when idle.
REQ-037 BITS=8, CLKDIV=2, pad returns 8'h81 -> Valid 33 cycles after Poll, Buttons[0]=8'h81.
REQ-038 Poll at cycle 0, Poll at 50, Poll at 60 (CLKDIV=4, BITS=16) -> exactly two Valid pulses, at cycles 129 and 258.
REQ-039 Pause high at cycles 40..59 during a scan -> CtlLatch/CtlClk frozen for those 20 cycles, Valid at cycle 149, data unchanged.
REQ-040 Reset at cycle 70 mid-scan -> cycle 71: Busy=0, CtlClk=1, CtlLatch=0, Buttons=0, no Valid. A new Poll then completes normally.
